// File: rtl/fifo_uart_tx.sv
// UART-style transmitter that drains a synchronous FIFO one word per frame.
// Frame: start bit, WIDTH data bits LSB-first, optional even parity, stop bit.
module fifo_uart_tx #(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter bit          PARITY_EN    = 1'b0
) (
    input  logic             clk_core,
    input  logic             rst_core,
    input  logic             tx_enable,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_read,
    output logic             tx,
    output logic             busy,
    output logic             frame_done,
    output logic [15:0]      words_sent
);

    localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
    localparam int unsigned IdxW  = $clog2(WIDTH) + 1;

    localparam logic [BaudW-1:0] BaudLast   = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [BaudW-1:0] BaudPenult = BaudW'(CLKS_PER_BIT - 2);
    localparam logic [IdxW-1:0]  IdxLast    = IdxW'(WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e             state_q;
    logic [BaudW-1:0]   baud_q;
    logic [IdxW-1:0]    bit_idx_q;
    logic [WIDTH-1:0]   shift_q;
    logic               parity_q;
    logic               tx_q;
    logic               busy_q;
    logic               frame_done_q;
    logic [15:0]        words_q;
    logic               baud_end;

    assign baud_end   = (baud_q == BaudLast);
    assign fifo_read  = (state_q == StFetch);
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign words_sent = words_q;

    // Line outputs are registered on the transition into each state, so they
    // change on the same edge as the state register.
    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
            state_q      <= StIdle;
            baud_q       <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            words_q      <= '0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (tx_enable && !fifo_empty) begin
                        state_q <= StFetch;
                        busy_q  <= 1'b1;
                    end
                end
                StFetch: begin
                    state_q <= StLoad;
                end
                StLoad: begin
                    shift_q   <= fifo_data;
                    baud_q    <= '0;
                    bit_idx_q <= '0;
                    parity_q  <= 1'b0;
                    tx_q      <= 1'b0;
                    state_q   <= StStart;
                end
                StStart: begin
                    if (baud_end) begin
                        baud_q  <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= StData;
                    end else begin
                        baud_q <= baud_q + BaudW'(1);
                    end
                end
                StData: begin
                    if (baud_end) begin
                        baud_q    <= '0;
                        parity_q  <= parity_q ^ shift_q[0];
                        shift_q   <= {1'b0, shift_q[WIDTH-1:1]};
                        bit_idx_q <= bit_idx_q + IdxW'(1);
                        if (bit_idx_q == IdxLast) begin
                            if (PARITY_EN) begin
                                tx_q    <= parity_q ^ shift_q[0];
                                state_q <= StParity;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= StStop;
                            end
                        end else begin
                            // Next data bit is already sitting one place up.
                            tx_q <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + BaudW'(1);
                    end
                end
                StParity: begin
                    if (baud_end) begin
                        baud_q  <= '0;
                        tx_q    <= 1'b1;
                        state_q <= StStop;
                    end else begin
                        baud_q <= baud_q + BaudW'(1);
                    end
                end
                StStop: begin
                    if (baud_end) begin
                        baud_q  <= '0;
                        busy_q  <= 1'b0;
                        words_q <= words_q + 16'd1;
                        state_q <= StIdle;
                    end else begin
                        baud_q <= baud_q + BaudW'(1);
                        // Raise the pulse so it lands on the final stop cycle.
                        if (baud_q == BaudPenult) begin
                            frame_done_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench: a FIFO model plus a frame-timeline reference model,
// compared every cycle, with literal expectations from hand-worked frames.
module tb_fifo_uart_tx;

    localparam int W   = 16;
    localparam int CPB = 4;

    logic        clk_core = 1'b0;
    logic        rst0, rst1;
    logic        tx_enable;
    logic        fifo_empty;
    logic [15:0] fifo_data;
    logic        pe;

    logic        rd0, tx0, busy0, fd0;
    logic        rd1, tx1, busy1, fd1;
    logic [15:0] ws0, ws1;

    logic        rd, txo, busyo, fdo, rst_sel;
    logic [15:0] wso;

    assign rd      = pe ? rd1 : rd0;
    assign txo     = pe ? tx1 : tx0;
    assign busyo   = pe ? busy1 : busy0;
    assign fdo     = pe ? fd1 : fd0;
    assign wso     = pe ? ws1 : ws0;
    assign rst_sel = pe ? rst1 : rst0;

    fifo_uart_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) u_dut (
        .clk_core   (clk_core),
        .rst_core   (rst0),
        .tx_enable  (tx_enable),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_read  (rd0),
        .tx         (tx0),
        .busy       (busy0),
        .frame_done (fd0),
        .words_sent (ws0)
    );

    fifo_uart_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) u_dut_par (
        .clk_core   (clk_core),
        .rst_core   (rst1),
        .tx_enable  (tx_enable),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_read  (rd1),
        .tx         (tx1),
        .busy       (busy1),
        .frame_done (fd1),
        .words_sent (ws1)
    );

    always #5 clk_core = ~clk_core;

    logic [15:0] fq[$];
    logic [15:0] mq[$];
    int          phase;
    logic [15:0] mword;
    logic [15:0] mwords;
    int          checks;
    int          errors;
    int          cyc;
    int          rd_cyc[$];
    int          fd_cnt;
    logic        txh[0:8191];
    int          word_bits[18] = '{0, 1, 1, 0, 0, 0, 0, 1, 1, 1, 0, 1, 0, 0, 1, 0, 1, 1};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int frame_len();
        return (W + 2 + (pe ? 1 : 0)) * CPB;
    endfunction

    task automatic cmp();
        int   k;
        int   b;
        logic etx;
        etx = 1'b1;
        if (phase >= 2) begin
            k = phase - 2;
            b = k / CPB;
            if (b == 0) etx = 1'b0;
            else if (b <= W) etx = mword[b-1];
            else if (pe && b == W + 1) etx = ^mword;
        end
        chk("tx", {31'd0, txo}, {31'd0, etx});
        chk("busy", {31'd0, busyo}, {31'd0, phase >= 0});
        chk("fifo_read", {31'd0, rd}, {31'd0, phase == 0});
        chk("frame_done", {31'd0, fdo}, {31'd0, (phase >= 2) && (phase - 2 == frame_len() - 1)});
        chk("words_sent", {16'd0, wso}, {16'd0, mwords});
    endtask

    task automatic tick();
        logic en_s, emp_s, rd_s, rst_s;
        @(negedge clk_core);
        cmp();
        if (cyc < 8192) txh[cyc] = txo;
        if (rd) rd_cyc.push_back(cyc);
        if (fdo) fd_cnt++;
        en_s  = tx_enable;
        emp_s = fifo_empty;
        rd_s  = rd;
        rst_s = rst_sel;
        @(posedge clk_core);
        #1;
        cyc++;
        if (rd_s && fq.size() > 0) fifo_data = fq.pop_front();
        fifo_empty = (fq.size() == 0);
        if (rst_s) begin
            phase = -1;
        end else if (phase < 0) begin
            if (en_s && !emp_s && mq.size() > 0) begin
                phase = 0;
                mword = mq.pop_front();
            end
        end else if (phase - 2 == frame_len() - 1) begin
            phase = -1;
            mwords++;
        end else begin
            phase++;
        end
    endtask

    task automatic push(input logic [15:0] w);
        fq.push_back(w);
        mq.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic do_reset();
        rst0 = 1'b1;
        rst1 = 1'b1;
        fq.delete();
        mq.delete();
        fifo_empty = 1'b1;
        fifo_data  = '0;
        phase  = -1;
        mwords = '0;
        tick();
        tick();
        if (pe) rst1 = 1'b0;
        else rst0 = 1'b0;
        rd_cyc.delete();
        fd_cnt = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int r0, r1;
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        pe        = 1'b0;
        tx_enable = 1'b0;
        do_reset();

        chk("reset_tx", {31'd0, txo}, 32'd1);
        chk("reset_busy", {31'd0, busyo}, 32'd0);
        chk("reset_read", {31'd0, rd}, 32'd0);
        chk("reset_done", {31'd0, fdo}, 32'd0);
        chk("reset_words", {16'd0, wso}, 32'd0);

        // Single word with a hand-derived bit pattern
        push(16'hA5C3);
        tx_enable = 1'b1;
        repeat (90) tick();
        chk("single_reads", rd_cyc.size(), 32'd1);
        chk("single_done", fd_cnt, 32'd1);
        chk("single_words", {16'd0, wso}, 32'd1);
        if (rd_cyc.size() >= 1) begin
            r0 = rd_cyc[0];
            chk("single_pre_start", {31'd0, txh[r0+1]}, 32'd1);
            for (int j = 0; j < 18; j++)
                for (int m = 0; m < CPB; m++)
                    chk("single_bit", {31'd0, txh[r0+2+CPB*j+m]}, word_bits[j]);
            chk("single_post_stop", {31'd0, txh[r0+2+72]}, 32'd1);
        end

        // Back-to-back
        do_reset();
        push(16'h0001);
        push(16'h8000);
        push(16'hFFFF);
        repeat (240) tick();
        chk("b2b_reads", rd_cyc.size(), 32'd3);
        chk("b2b_done", fd_cnt, 32'd3);
        chk("b2b_words", {16'd0, wso}, 32'd3);
        chk("b2b_idle", {31'd0, busyo}, 32'd0);
        if (rd_cyc.size() >= 3) begin
            chk("b2b_gap1", rd_cyc[1] - rd_cyc[0], 32'd75);
            chk("b2b_gap2", rd_cyc[2] - rd_cyc[1], 32'd75);
        end

        // Empty FIFO while enabled, then queued words while disabled
        do_reset();
        repeat (200) tick();
        chk("empty_reads", rd_cyc.size(), 32'd0);
        tx_enable = 1'b0;
        push(16'h1357);
        push(16'h2468);
        repeat (50) tick();
        chk("disabled_reads", rd_cyc.size(), 32'd0);
        chk("disabled_tx", {31'd0, txo}, 32'd1);

        // Enable drop in the middle of data bit 5
        tx_enable = 1'b1;
        repeat (30) tick();
        tx_enable = 1'b0;
        repeat (150) tick();
        chk("drop_reads", rd_cyc.size(), 32'd1);
        chk("drop_words", {16'd0, wso}, 32'd1);
        tx_enable = 1'b1;
        repeat (100) tick();
        chk("reenable_reads", rd_cyc.size(), 32'd2);
        chk("reenable_words", {16'd0, wso}, 32'd2);

        // Asynchronous reset during DATA of an all-zero word
        do_reset();
        push(16'h0000);
        push(16'h1234);
        repeat (20) tick();
        chk("pre_reset_tx", {31'd0, txo}, 32'd0);
        #2;
        rst0 = 1'b1;
        #1;
        chk("async_tx", {31'd0, txo}, 32'd1);
        chk("async_busy", {31'd0, busyo}, 32'd0);
        chk("async_words", {16'd0, wso}, 32'd0);
        phase  = -1;
        mwords = '0;
        tick();
        rst0 = 1'b0;
        rd_cyc.delete();
        repeat (90) tick();
        chk("post_reset_reads", rd_cyc.size(), 32'd1);
        chk("post_reset_words", {16'd0, wso}, 32'd1);

        // Even parity on the second instance
        pe = 1'b1;
        do_reset();
        push(16'h0007);
        push(16'h0003);
        repeat (170) tick();
        chk("par_reads", rd_cyc.size(), 32'd2);
        chk("par_words", {16'd0, wso}, 32'd2);
        if (rd_cyc.size() >= 2) begin
            r0 = rd_cyc[0];
            r1 = rd_cyc[1];
            chk("par_gap", r1 - r0, 32'd79);
            for (int m = 0; m < CPB; m++) begin
                chk("par_bit_0007", {31'd0, txh[r0+2+68+m]}, 32'd1);
                chk("par_bit_0003", {31'd0, txh[r1+2+68+m]}, 32'd0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
